axis_pattern_burst_ctrl: RTL

//  Sequences the test-pattern generator: drives its enable, gates its AXIS

---
 rtl/axis_tpg_pkg.sv | 17 +
 rtl/axis_pattern_burst_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/axis_tpg_pkg.sv
// rtl/axis_tpg_pkg.sv - shared state encoding and defaults for the test-pattern burst controller
package axis_tpg_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int DEF_BURST_LEN  = 64;
   localparam int DEF_GAP_CYCLES = 16;

   // Bits needed to hold 0..max_val, never fewer than one.
   function automatic int cnt_bits(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/axis_pattern_burst_ctrl.sv
// rtl/axis_pattern_burst_ctrl.sv - gates pattern-generator AXIS into fixed-length packets with idle gaps
module axis_pattern_burst_ctrl
   import axis_tpg_pkg::*;
#(
   parameter int TDATA_WIDTH = 32,
   parameter int BURST_LEN   = DEF_BURST_LEN,
   parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                   m_axis_aclk,
   input  logic                   m_axis_aresetn,
   input  logic                   start,
   input  logic                   stop,
   input  logic [CNT_WIDTH-1:0]   num_bursts,
   output logic                   gen_enable,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_WIDTH-1:0]   bursts_sent
);

   localparam int BEAT_W = cnt_bits(BURST_LEN);
   localparam int GAP_W  = cnt_bits(GAP_CYCLES);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [1:0]           state_q, state_d;
   logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
   logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
   logic [CNT_WIDTH-1:0] bursts_sent_q, bursts_sent_d;
   logic [CNT_WIDTH-1:0] num_lat_q, num_lat_d;
   logic                 stop_pending_q, stop_pending_d;
   logic                 gen_enable_q, gen_enable_d;
   logic [CNT_WIDTH-1:0] sent_inc;
   logic                 run;
   logic                 beat;

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state_q        <= ST_IDLE;
         beat_cnt_q     <= '0;
         gap_cnt_q      <= '0;
         bursts_sent_q  <= '0;
         num_lat_q      <= '0;
         stop_pending_q <= 1'b0;
         gen_enable_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         beat_cnt_q     <= beat_cnt_d;
         gap_cnt_q      <= gap_cnt_d;
         bursts_sent_q  <= bursts_sent_d;
         num_lat_q      <= num_lat_d;
         stop_pending_q <= stop_pending_d;
         gen_enable_q   <= gen_enable_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      beat_cnt_d     = beat_cnt_q;
      gap_cnt_d      = gap_cnt_q;
      bursts_sent_d  = bursts_sent_q;
      num_lat_d      = num_lat_q;
      stop_pending_d = stop_pending_q;
      sent_inc       = bursts_sent_q + 1'b1;
      gen_enable_d   = (state_q == ST_RUN) || (state_q == ST_GAP);
      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               state_d       = ST_RUN;
               num_lat_d     = num_bursts;
               bursts_sent_d = '0;
               beat_cnt_d    = '0;
            end
         end
         ST_RUN: begin
            if (stop) stop_pending_d = 1'b1;
            if (beat) begin
               if (beat_cnt_q == LAST_BEAT) begin
                  beat_cnt_d    = '0;
                  bursts_sent_d = sent_inc;
                  // A stop arriving with the last beat still ends the sequence here.
                  if (stop_pending_q || stop || ((num_lat_q != '0) && (sent_inc == num_lat_q))) begin
                     state_d = ST_DONE;
                  end else if (GAP_CYCLES == 0) begin
                     state_d = ST_RUN;
                  end else begin
                     state_d   = ST_GAP;
                     gap_cnt_d = GAP_INIT;
                  end
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         ST_GAP: begin
            if (stop || stop_pending_q) begin
               state_d = ST_DONE;
            end else if (gap_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               gap_cnt_d = gap_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d == ST_IDLE) stop_pending_d = 1'b0;
   end

   always_comb begin
      run           = (state_q == ST_RUN);
      m_axis_tdata  = s_axis_tdata;
      m_axis_tvalid = s_axis_tvalid & run;
      s_axis_tready = m_axis_tready & run;
      beat          = m_axis_tvalid & m_axis_tready;
      m_axis_tlast  = run & (beat_cnt_q == LAST_BEAT);
      busy          = (state_q != ST_IDLE);
      done          = (state_q == ST_DONE);
      gen_enable    = gen_enable_q;
      bursts_sent   = bursts_sent_q;
   end

endmodule
